mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter that shares the single-port 32-bit data memory (256 words, combinational read, synchronous write) between the MCU instruction-fetch port (master 0) and the load/store port (master 1). The arbiter performs at most one memory access per cycle and grants masters round-robin. It supports a lock for atomic read-modify-write sequences, range-checks addresses, and returns registered responses with fixed one-cycle latency.

## Interface
- DEPTH, 256: memory word count; must match the attached memory's size.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- m0_req / m1_req  input  1  access request; held with stable payload until granted
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_lock / m1_lock  input  1  keep ownership after this access is granted
- m0_addr / m1_addr  input  32  word address
- m0_wdata / m1_wdata  input  32  write data
- m0_gnt / m1_gnt  output  1  access performed this cycle (combinational)
- m0_rvalid / m1_rvalid  output  1  response pulse, one cycle after gnt
- m0_rdata / m1_rdata  output  32  read data, or write data echo
- m0_err / m1_err  output  1  address out of range, valid with rvalid
- mem_address  output  32  to memory address
- mem_we  output  1  to memory write enable
- mem_write_data  output  32  to memory write data
- mem_read_data  input  32  from memory read data

## Operation
- Arbiter state: ARB, LOCK0, LOCK1. Round-robin pointer `last` (0/1). Reset: state ARB, last = 1, so master 0 wins the first tie.
- ARB, one requester: that master is granted.
- ARB, both requesting: grant the master != last. On any grant, last <= granted index.
- Granted with lock=1: next state LOCK<n>. In LOCKn only master n can be granted; the other master's gnt stays 0 even if it is the sole requester.
- LOCKn, master n granted with lock=0: return to ARB.
- LOCKn, master n idle: stay in LOCKn; no timeout.
- Memory drive:
  - Granted master's addr and wdata go to mem_address and mem_write_data.
  - mem_we = granted we AND in-range.
  - With no grant, mem_address = 0, mem_write_data = 0 and mem_we = 0.
- Range check: in-range iff addr < DEPTH. An out-of-range access is still granted (consumes the slot), mem_we is forced 0, and the response has err=1 and rdata = 0.
- Response register, captured at the grant edge and routed to the granted master only:
  - read: rdata <= mem_read_data
  - in-range write: rdata <= wdata, the memory's write-forward value
  - rvalid <= 1
  - err <= out-of-range
- The non-granted master's rvalid, rdata and err are 0 in the following cycle.

## Timing
- gnt and mem_* are combinational from req/state in the same cycle. The write commits at the rising edge ending the grant cycle.
- Latency: rvalid exactly 1 cycle after gnt. Throughput: one access per cycle total, back-to-back grants allowed, including alternating masters.
- Read after write to the same address on consecutive grants returns the new data.
- Reset values:
  - all gnt 0, all rvalid 0, all rdata 0, all err 0
  - mem_we 0, mem_address 0, mem_write_data 0
  - state ARB, last = 1
- Reset asserted mid-operation (including in LOCKn or with a pending rvalid): all outputs clear asynchronously, and no response is delivered for the interrupted access.
- Request dropped before grant: no access and no response. Masters must not do this; the arbiter does not flag it.

## Test plan
- Reset then single read: m0_req=1, we=0, addr=0x10 -> m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0x00000000, m1_rvalid=0.
- Write then read: m1 writes 0xDEADBEEF to 0x05 (gnt cycle N), then reads 0x05 at cycle N+1 -> rvalid at N+1 with rdata 0xDEADBEEF, and at N+2 with rdata 0xDEADBEEF.
- Contention: both request continuously from reset -> grants alternate m0, m1, m0, m1; each master gets exactly one rvalid per grant.
- Lock: m1 granted with lock=1 reading 0x20 while m0 requests -> m0_gnt=0 until m1's next granted access with lock=0 writes 0x20; m0 is granted the cycle after.
- Out of range: m0 writes 0x12345678 to addr 256 -> m0_gnt=1, mem_we=0; next cycle m0_err=1, m0_rdata=0. A follow-up read of addr 0 (256 mod 256) returns the prior value, unchanged.
- Reset mid-lock: m0 in LOCK0 with rvalid pending; pulse rst_n low -> rvalid 0 immediately; after release, a lone m1 request is granted in the first cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin two-master arbiter for a single-port memory,
//                    with lock support, range checking and 1-cycle responses
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_address,
  output logic        mem_we,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        last, last_next;
  logic        gnt0, gnt1, any_gnt;
  logic        sel_we, in_range;
  logic [31:0] sel_addr, sel_wdata, resp_data;

  // Grants are held off while reset is asserted so outputs read as idle.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = state;
    last_next  = last;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (m0_req && (!m1_req || last)) gnt0 = 1'b1;
          else if (m1_req)                 gnt1 = 1'b1;
        end
        LOCK0:   gnt0 = m0_req;
        LOCK1:   gnt1 = m1_req;
        default: ;
      endcase
    end
    if (gnt0) begin
      state_next = m0_lock ? LOCK0 : ARB;
      last_next  = 1'b0;
    end else if (gnt1) begin
      state_next = m1_lock ? LOCK1 : ARB;
      last_next  = 1'b1;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign sel_we    = gnt1 ? m1_we    : m0_we;
  assign in_range  = sel_addr < DEPTH_W;

  assign m0_gnt         = gnt0;
  assign m1_gnt         = gnt1;
  assign mem_address    = any_gnt ? sel_addr  : 32'd0;
  assign mem_write_data = any_gnt ? sel_wdata : 32'd0;
  assign mem_we         = any_gnt & sel_we & in_range;

  // Writes echo their data, matching what the memory would forward.
  assign resp_data = !in_range ? 32'd0 : (sel_we ? sel_wdata : mem_read_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      last      <= 1'b1;
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'd0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'd0;
      m1_err    <= 1'b0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      m0_rvalid <= gnt0;
      m0_rdata  <= gnt0 ? resp_data : 32'd0;
      m0_err    <= gnt0 & ~in_range;
      m1_rvalid <= gnt1;
      m1_rdata  <= gnt1 ? resp_data : 32'd0;
      m1_err    <= gnt1 & ~in_range;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, synchronous write.
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_address[7:0]] <= mem_write_data;

  mem_port_arbiter #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    m0_req = 1; m1_req = 1; m0_addr = 32'h33; m1_addr = 32'h44;
    #12;
    n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt got %b exp 0", m0_gnt); end
    n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt got %b exp 0", m1_gnt); end
    n_checks++; if ({mem_we, mem_address, mem_write_data} !== 65'd0) begin n_fail++; $display("FAIL reset_mem got we=%b a=%h d=%h exp 0", mem_we, mem_address, mem_write_data); end
    n_checks++; if ({m0_rvalid, m0_rdata, m0_err, m1_rvalid, m1_rdata, m1_err} !== 68'd0) begin n_fail++; $display("FAIL reset_resp got rv0=%b rd0=%h e0=%b rv1=%b rd1=%h e1=%b exp 0", m0_rvalid, m0_rdata, m0_err, m1_rvalid, m1_rdata, m1_err); end
    idle();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); m0_req = 1; m0_addr = 32'h10;
    #1;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt got %b exp 1", m0_gnt); end
    n_checks++; if (mem_address !== 32'h10 || mem_we !== 1'b0) begin n_fail++; $display("FAIL single_mem got a=%h we=%b exp a=10 we=0", mem_address, mem_we); end
    @(posedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0 || m0_err !== 1'b0) begin n_fail++; $display("FAIL single_resp got rv=%b rd=%h e=%b exp 1/0/0", m0_rvalid, m0_rdata, m0_err); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_m1_rvalid got %b exp 0", m1_rvalid); end
    @(negedge clk); idle();
  endtask

  task automatic test_write_read();
    @(negedge clk); m1_req = 1; m1_we = 1; m1_addr = 32'h05; m1_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_drive got gnt=%b we=%b d=%h exp 1/1/deadbeef", m1_gnt, mem_we, mem_write_data); end
    @(posedge clk); #1;
    n_checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_echo got rv=%b rd=%h exp 1/deadbeef", m1_rvalid, m1_rdata); end
    @(negedge clk); m1_we = 0; m1_wdata = 0;
    #1;
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got %b exp 1", m1_gnt); end
    @(posedge clk); #1;
    n_checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_read got rv=%b rd=%h exp 1/deadbeef", m1_rvalid, m1_rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_contention();
    logic exp0;
    @(negedge clk); m0_req = 1; m0_addr = 32'h1; m1_req = 1; m1_addr = 32'h2;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      if (i != 0) @(negedge clk);
      #1;
      n_checks++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin n_fail++; $display("FAIL rr_gnt[%0d] got g0=%b g1=%b exp g0=%b", i, m0_gnt, m1_gnt, exp0); end
      @(posedge clk); #1;
      n_checks++; if (m0_rvalid !== exp0 || m1_rvalid !== !exp0) begin n_fail++; $display("FAIL rr_rvalid[%0d] got rv0=%b rv1=%b exp rv0=%b", i, m0_rvalid, m1_rvalid, exp0); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_lock();
    @(negedge clk); m1_req = 1; m1_lock = 1; m1_addr = 32'h20;
    #1;
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_take got %b exp 1", m1_gnt); end
    @(negedge clk); idle(); m0_req = 1; m0_addr = 32'h20;
    #1;
    n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_hold got g0=%b g1=%b exp 0/0", m0_gnt, m1_gnt); end
    @(posedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL lock_m0_rvalid got %b exp 0", m0_rvalid); end
    @(negedge clk); m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
    #1;
    n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_we !== 1'b1) begin n_fail++; $display("FAIL lock_release got g1=%b g0=%b we=%b exp 1/0/1", m1_gnt, m0_gnt, mem_we); end
    @(negedge clk); m1_req = 0; m1_we = 0; m1_lock = 0;
    #1;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_after got %b exp 1", m0_gnt); end
    @(posedge clk); #1;
    n_checks++; if (m0_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lock_readback got %h exp a5a5a5a5", m0_rdata); end
    @(negedge clk); idle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk); m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h11112222;
    @(negedge clk); m0_addr = 32'd256; m0_wdata = 32'h12345678;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_drive got gnt=%b we=%b exp 1/0", m0_gnt, mem_we); end
    @(posedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_resp got rv=%b e=%b rd=%h exp 1/1/0", m0_rvalid, m0_err, m0_rdata); end
    @(negedge clk); m0_we = 0; m0_addr = 32'h0; m0_wdata = 0;
    @(posedge clk); #1;
    n_checks++; if (m0_rdata !== 32'h11112222 || m0_err !== 1'b0) begin n_fail++; $display("FAIL oor_intact got rd=%h e=%b exp 11112222/0", m0_rdata, m0_err); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk); m0_req = 1; m0_lock = 1; m0_addr = 32'h0;
    @(posedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL rml_pending got %b exp 1", m0_rvalid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rml_clear got rv=%b rd=%h g=%b exp 0/0/0", m0_rvalid, m0_rdata, m0_gnt); end
    idle();
    #1 rst_n = 1'b1;
    @(negedge clk); m1_req = 1; m1_addr = 32'h7;
    #1;
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_m1_gnt got %b exp 1", m1_gnt); end
    @(posedge clk); #1;
    n_checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rml_resp got rv1=%b rv0=%b exp 1/0", m1_rvalid, m0_rvalid); end
    @(negedge clk); idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_lock();
    test_out_of_range();
    test_reset_mid_lock();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
